time_setter: RTL and testbench
==============================

# time_setter

Button-driven time-entry controller that drives the load side of `alarm_clock`: its BCD digit outputs and `LD_time`/`LD_alarm` strobes connect directly to the clock's `H_in*`/`M_in*`/`LD_*` inputs. Four raw push-buttons let the user edit hours and minutes with BCD-correct wrap-around and commit them as either the clock time or the alarm time. The block also keeps a shadow copy of the last committed alarm, because `alarm_clock` does not output it. It runs on the same clock as `alarm_clock`.

## Interface
- `DB_CYCLES`, default 3: consecutive high samples required for a button press.
- `LD_PULSE`, default 1: number of cycles `LD_time`/`LD_alarm` stays high on commit.
- `TIMEOUT`, default 600: idle cycles in edit before an automatic abort (60 s at 10 Hz).
- `clk` in 1: system clock. Single clock domain; reset is synchronous and active-low.
- `reset` in 1: synchronous, active-low; 0 = reset, sampled on the `clk` rising edge.
- `btn_time`, `btn_alarm`, `btn_next`, `btn_ok` in 1 each: raw active-high buttons.
- `btn_up` in 1: raw active-high button.
- `cur_H1` in 2, `cur_H0`/`cur_M1`/`cur_M0` in 4 each: current clock time (BCD) from `alarm_clock`.
- `H_in1` out 2, `H_in0`/`M_in1`/`M_in0` out 4 each: edit digits (BCD) to `alarm_clock`.
- `LD_time`, `LD_alarm` out 1 each: load strobes to `alarm_clock`.
- `editing` out 1: high in `EDIT_H`/`EDIT_M`.
- `field` out 1: 0 = hours selected, 1 = minutes selected.
- `target` out 1: 0 = time, 1 = alarm.

## Operation
- Debounce (one `btn_debounce` per button):
  - Emits a 1-cycle `press` on the cycle the input has been sampled high for the `DB_CYCLES`-th consecutive time.
  - Re-arms only after the input is sampled low.
  - Holding a button produces exactly one press.
- FSM states: `IDLE`, `EDIT_H`, `EDIT_M`, `COMMIT`.
- In `IDLE`:
  - `btn_time` press: load edit regs from `cur_*`, set `target`=0, go to `EDIT_H`.
  - `btn_alarm` press: load edit regs from the alarm shadow, set `target`=1, go to `EDIT_H`.
  - `btn_up`, `btn_next` and `btn_ok` are ignored.
- In `EDIT_H`/`EDIT_M`:
  - `btn_up`: BCD-increment the selected field.
  - `btn_next`: toggle between `EDIT_H` and `EDIT_M`.
  - `btn_ok`: go to `COMMIT`.
  - `btn_time` or `btn_alarm`: cancel to `IDLE`. Edit regs revert to the last committed values; no strobe.
  - `TIMEOUT` cycles with no press events: same as cancel.
- `COMMIT`:
  - Assert `LD_time` (`target`=0) or `LD_alarm` (`target`=1) for `LD_PULSE` cycles, then go to `IDLE`.
  - When `target`=1, the alarm shadow ← edit regs.
- Hours increment: 23 → 00; x9 → (x+1)0; otherwise H0+1. Range 00–23.
- Minutes increment: 59 → 00; x9 → (x+1)0; otherwise M0+1. Range 00–59.
- Capture clamp: any captured value that is invalid BCD or out of range (H1>2, H0>9, H1:H0>23, M1>5, M0>9) is replaced by 00 for that field.
- Simultaneous press events in one cycle, priority order: `btn_time`/`btn_alarm` (cancel or enter; `btn_time` wins over `btn_alarm`) > `btn_ok` > `btn_next` > `btn_up`. Only one event acts per cycle; the others are dropped.
- Digit outputs always show the edit registers. In `IDLE` these are the last committed (or reverted) values.

## Timing
- Reset values:
  - All digit outputs, the alarm shadow and the "last committed" registers: 0 (00:00).
  - `LD_time`, `LD_alarm`, `editing`, `field`, `target`: 0.
  - State `IDLE`; debounce counters 0; timeout counter 0.
- Press latency: button rises at edge k, `press` is high at edge k+`DB_CYCLES`-1, the FSM or register update is visible after edge k+`DB_CYCLES`.
- Commit:
  - `LD_*` rises on the cycle after the `btn_ok` press event.
  - Digits are stable from at least one cycle before `LD_*` rises until it falls.
  - `IDLE` is entered on the cycle after the last `LD_*` cycle.
- Timeout counter: clears on every press event; abort occurs when it reaches `TIMEOUT`-1.
- Reset asserted mid-edit or mid-`COMMIT`: `LD_*` is low on the very next edge, the shadow is unchanged unless the write had already completed, state is `IDLE`.

## Structure
- Shared package `clock_pkg`: FSM state enum, `MAX_HOUR`=23, `MAX_MIN`=59, BCD digit widths (2/4), `target` encodings.
- Sub-module `btn_debounce`: `DB_CYCLES` counter plus re-arm flag; instantiated five times.
- Top level holds the FSM, BCD incrementers, edit/committed/shadow registers and the timeout counter.

## Test plan
- Reset, then press `btn_time` with `cur`=13:47, then `up` ×11, then `ok` → `H_in` shows 00:47; `LD_time` high exactly 1 cycle; `editing` falls afterwards.
- Press `btn_alarm`, then `next`, then `up` ×61 → minutes wrap 59→00 and read 01; after `ok`: `LD_alarm` pulse, shadow 00:01; a second `btn_alarm` re-enters showing 00:01.
- Hold `btn_up` for 20 cycles with `DB_CYCLES`=3 → exactly one increment. Glitch of 2 cycles high → no increment.
- Enter edit, make 2 edits, then idle for `TIMEOUT` cycles → `IDLE`, digits revert to the prior committed values, no `LD_*` pulse.
- Capture `cur`=27:6A (invalid) → edit shows 00:00. Same-cycle `ok`+`up` events → commit only, value unchanged.
- Pull `reset`=0 during the `COMMIT` cycle → `LD_*` low on the next edge, all outputs 0, state `IDLE`.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the alarm-clock time-entry path.
package clock_pkg;

    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_e;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int H1_W     = 2;
    localparam int DIG_W    = 4;

    localparam logic TGT_TIME  = 1'b0;
    localparam logic TGT_ALARM = 1'b1;

    localparam int NUM_BTN   = 5;
    localparam int BTN_TIME  = 0;
    localparam int BTN_ALARM = 1;
    localparam int BTN_NEXT  = 2;
    localparam int BTN_OK    = 3;
    localparam int BTN_UP    = 4;

    typedef struct packed {
        logic [H1_W-1:0]  h1;
        logic [DIG_W-1:0] h0;
        logic [DIG_W-1:0] m1;
        logic [DIG_W-1:0] m0;
    } hhmm_t;

    function automatic hhmm_t inc_hours(hhmm_t t);
        hhmm_t r = t;
        if (t.h1 == H1_W'(MAX_HOUR / 10) && t.h0 == DIG_W'(MAX_HOUR % 10)) begin
            r.h1 = '0;
            r.h0 = '0;
        end else if (t.h0 == DIG_W'(9)) begin
            r.h1 = t.h1 + H1_W'(1);
            r.h0 = '0;
        end else begin
            r.h0 = t.h0 + DIG_W'(1);
        end
        return r;
    endfunction

    function automatic hhmm_t inc_mins(hhmm_t t);
        hhmm_t r = t;
        if (t.m1 == DIG_W'(MAX_MIN / 10) && t.m0 == DIG_W'(MAX_MIN % 10)) begin
            r.m1 = '0;
            r.m0 = '0;
        end else if (t.m0 == DIG_W'(9)) begin
            r.m1 = t.m1 + DIG_W'(1);
            r.m0 = '0;
        end else begin
            r.m0 = t.m0 + DIG_W'(1);
        end
        return r;
    endfunction

    // Each field is zeroed independently when it is not a legal BCD value.
    function automatic hhmm_t clamp_hm(hhmm_t t);
        hhmm_t r = t;
        if (t.h0 > DIG_W'(9) || t.h1 > H1_W'(MAX_HOUR / 10) ||
            (t.h1 == H1_W'(MAX_HOUR / 10) && t.h0 > DIG_W'(MAX_HOUR % 10))) begin
            r.h1 = '0;
            r.h0 = '0;
        end
        if (t.m1 > DIG_W'(MAX_MIN / 10) || t.m0 > DIG_W'(9)) begin
            r.m1 = '0;
            r.m0 = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to single-cycle press event; a hold yields one press.
module btn_debounce #(
    parameter int DB_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        press_d = 1'b0;
        if (!btn) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                press_d = 1'b1;
                armed_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Disarmed out of reset so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/time_setter.sv
// Button-driven hours/minutes editor feeding the alarm_clock load port.
module time_setter
    import clock_pkg::*;
#(
    parameter int DB_CYCLES = 3,
    parameter int LD_PULSE  = 1,
    parameter int TIMEOUT   = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_next,
    input  logic       btn_ok,
    input  logic       btn_up,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [3:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic       field,
    output logic       target
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(LD_PULSE + 1);

    logic [NUM_BTN-1:0] btn_raw, press;
    assign btn_raw = {btn_up, btn_ok, btn_next, btn_alarm, btn_time};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw[i]),
            .press(press[i])
        );
    end

    state_e        state_q, state_d;
    hhmm_t         edit_q, edit_d;
    hhmm_t         comm_q, comm_d;
    hhmm_t         shadow_q, shadow_d;
    logic          target_q, target_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] pls_q, pls_d;
    hhmm_t         cap;

    assign cap = clamp_hm({cur_H1, cur_H0, cur_M1, cur_M0});

    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        comm_d   = comm_q;
        shadow_d = shadow_q;
        target_d = target_q;
        tmo_d    = '0;
        pls_d    = '0;
        case (state_q)
            IDLE: begin
                if (press[BTN_TIME]) begin
                    edit_d   = cap;
                    target_d = TGT_TIME;
                    state_d  = EDIT_H;
                end else if (press[BTN_ALARM]) begin
                    edit_d   = shadow_q;
                    target_d = TGT_ALARM;
                    state_d  = EDIT_H;
                end
            end
            EDIT_H, EDIT_M: begin
                tmo_d = (|press) ? '0 : tmo_q + TW'(1);
                if (press[BTN_TIME] || press[BTN_ALARM]) begin
                    edit_d  = comm_q;
                    state_d = IDLE;
                end else if (press[BTN_OK]) begin
                    state_d = COMMIT;
                end else if (press[BTN_NEXT]) begin
                    state_d = (state_q == EDIT_H) ? EDIT_M : EDIT_H;
                end else if (press[BTN_UP]) begin
                    edit_d = (state_q == EDIT_H) ? inc_hours(edit_q) : inc_mins(edit_q);
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    edit_d  = comm_q;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                // Registers update on the last strobe cycle, so a reset inside COMMIT discards them.
                if (pls_q == PW'(LD_PULSE - 1)) begin
                    state_d = IDLE;
                    comm_d  = edit_q;
                    if (target_q == TGT_ALARM) shadow_d = edit_q;
                end else begin
                    pls_d = pls_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            edit_q   <= '0;
            comm_q   <= '0;
            shadow_q <= '0;
            target_q <= TGT_TIME;
            tmo_q    <= '0;
            pls_q    <= '0;
        end else begin
            state_q  <= state_d;
            edit_q   <= edit_d;
            comm_q   <= comm_d;
            shadow_q <= shadow_d;
            target_q <= target_d;
            tmo_q    <= tmo_d;
            pls_q    <= pls_d;
        end
    end

    assign H_in1    = edit_q.h1;
    assign H_in0    = edit_q.h0;
    assign M_in1    = edit_q.m1;
    assign M_in0    = edit_q.m0;
    assign LD_time  = (state_q == COMMIT) && (target_q == TGT_TIME);
    assign LD_alarm = (state_q == COMMIT) && (target_q == TGT_ALARM);
    assign editing  = (state_q == EDIT_H) || (state_q == EDIT_M);
    assign field    = (state_q == EDIT_M);
    assign target   = target_q;

endmodule

// File: tb/tb_time_setter.sv
// Randomized + directed bench for time_setter with an integer-arithmetic reference model.
module tb_time_setter;
    localparam int DB  = 3;
    localparam int LDP = 1;
    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_time = 1'b0, btn_alarm = 1'b0, btn_next = 1'b0, btn_ok = 1'b0, btn_up = 1'b0;
    logic [1:0] cur_H1 = '0;
    logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, editing, field, target;

    time_setter #(.DB_CYCLES(DB), .LD_PULSE(LDP), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .btn_time(btn_time), .btn_alarm(btn_alarm), .btn_next(btn_next),
        .btn_ok(btn_ok), .btn_up(btn_up),
        .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .editing(editing), .field(field), .target(target)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int tgt;
        int hh;
        int mm;
    } exp_t;
    exp_t expq[$];

    // Reference model: plain integers, hours 0..23, minutes 0..59.
    int m_edit = 0, m_sel = 0, m_tgt = 0;
    int m_eh = 0, m_em = 0, m_ch = 0, m_cm = 0, m_sh = 0, m_sm = 0;

    function automatic int bcd(input int h, input int m);
        return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
    endfunction

    function automatic int dut_digits();
        return int'({H_in1, H_in0, M_in1, M_in0});
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".editing"}, int'(editing), m_edit);
        chk({tag, ".field"}, int'(field), m_edit ? m_sel : 0);
        chk({tag, ".target"}, int'(target), m_tgt);
        chk({tag, ".digits"}, dut_digits(), bcd(m_eh, m_em));
    endtask

    task automatic model_reset();
        m_edit = 0; m_sel = 0; m_tgt = 0;
        m_eh = 0; m_em = 0; m_ch = 0; m_cm = 0; m_sh = 0; m_sm = 0;
    endtask

    task automatic model_revert();
        m_eh = m_ch; m_em = m_cm; m_edit = 0; m_sel = 0;
    endtask

    // mask bits: 0 time, 1 alarm, 2 next, 3 ok, 4 up
    task automatic model_press(input logic [4:0] mask);
        int h, m;
        if (!m_edit) begin
            if (mask[0]) begin
                h = int'(cur_H1) * 10 + int'(cur_H0);
                m = int'(cur_M1) * 10 + int'(cur_M0);
                if (cur_H0 > 9 || h > 23) h = 0;
                if (cur_M1 > 5 || cur_M0 > 9) m = 0;
                m_eh = h; m_em = m; m_tgt = 0; m_edit = 1; m_sel = 0;
            end else if (mask[1]) begin
                m_eh = m_sh; m_em = m_sm; m_tgt = 1; m_edit = 1; m_sel = 0;
            end
        end else begin
            if (mask[0] || mask[1]) begin
                model_revert();
            end else if (mask[3]) begin
                expq.push_back('{m_tgt, m_eh, m_em});
                m_ch = m_eh; m_cm = m_em;
                if (m_tgt == 1) begin m_sh = m_eh; m_sm = m_em; end
                m_edit = 0; m_sel = 0;
            end else if (mask[2]) begin
                m_sel = 1 - m_sel;
            end else if (mask[4]) begin
                if (m_sel == 0) m_eh = (m_eh + 1) % 24;
                else            m_em = (m_em + 1) % 60;
            end
        end
    endtask

    task automatic drive(input logic [4:0] mask, input logic v);
        if (mask[0]) btn_time  = v;
        if (mask[1]) btn_alarm = v;
        if (mask[2]) btn_next  = v;
        if (mask[3]) btn_ok    = v;
        if (mask[4]) btn_up    = v;
    endtask

    task automatic press(input logic [4:0] mask, input int hold, input string tag);
        @(negedge clk);
        drive(mask, 1'b1);
        if (hold >= DB) model_press(mask);
        repeat (hold) @(negedge clk);
        drive(mask, 1'b0);
        repeat (2) @(negedge clk);
        check_state(tag);
    endtask

    // Monitor: every strobe pulse must match the oldest expected commit.
    int   pulse_len = 0;
    bit   in_pulse = 0;
    exp_t cur_exp;
    always @(negedge clk) begin
        if (LD_time || LD_alarm) begin
            if (!in_pulse) begin
                in_pulse  = 1;
                pulse_len = 0;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ld_spurious: strobe time=%0b alarm=%0b with no commit expected at %0t",
                             LD_time, LD_alarm, $time);
                    cur_exp = '{-1, 0, 0};
                end else begin
                    cur_exp = expq.pop_front();
                end
            end
            pulse_len++;
            if (cur_exp.tgt >= 0) begin
                chk("ld_time", int'(LD_time), int'(cur_exp.tgt == 0));
                chk("ld_alarm", int'(LD_alarm), int'(cur_exp.tgt == 1));
                chk("ld_digits", dut_digits(), bcd(cur_exp.hh, cur_exp.mm));
            end
        end else if (in_pulse) begin
            in_pulse = 0;
            chk("ld_len", pulse_len, LDP);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [4:0] mask;
        int op;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset.ld", int'({LD_time, LD_alarm}), 0);
        reset = 1'b1;

        // Enter time edit from 13:47 with a latency check
        cur_H1 = 2'd1; cur_H0 = 4'd3; cur_M1 = 4'd4; cur_M0 = 4'd7;
        @(negedge clk);
        btn_time = 1'b1;
        model_press(5'b00001);
        repeat (3) @(negedge clk);
        chk("latency.before", int'(editing), 0);
        @(negedge clk);
        chk("latency.after", int'(editing), 1);
        btn_time = 1'b0;
        @(negedge clk);
        check_state("enter_time");
        for (int i = 0; i < 11; i++) press(5'b10000, DB, "up_hours");
        chk("hours_wrap", dut_digits(), bcd(0, 47));
        press(5'b01000, DB, "ok_time");

        // Alarm edit, minutes wrap through 59 -> 00 -> 01
        press(5'b00010, DB, "enter_alarm");
        press(5'b00100, DB, "next");
        for (int i = 0; i < 61; i++) press(5'b10000, DB, "up_mins");
        chk("mins_wrap", dut_digits(), bcd(0, 1));
        press(5'b01000, DB, "ok_alarm");
        press(5'b00010, DB, "reenter_alarm");
        chk("shadow", dut_digits(), bcd(0, 1));
        press(5'b00001, DB, "cancel");

        // Hold and glitch filtering
        cur_H1 = 2'd0; cur_H0 = 4'd9; cur_M1 = 4'd5; cur_M0 = 4'd9;
        press(5'b00001, DB, "enter_time2");
        press(5'b10000, 20, "hold_up");
        chk("hold_one_inc", dut_digits(), bcd(10, 59));
        press(5'b10000, 2, "glitch_up");
        chk("glitch_no_inc", dut_digits(), bcd(10, 59));

        // Timeout after two edits
        press(5'b00100, DB, "next2");
        press(5'b10000, DB, "up_min2");
        repeat (TMO - 2) @(negedge clk);
        chk("timeout.before", int'(editing), 1);
        @(negedge clk);
        model_revert();
        check_state("timeout.after");

        // Invalid capture clamps; ok beats up
        cur_H1 = 2'd2; cur_H0 = 4'd7; cur_M1 = 4'd6; cur_M0 = 4'hA;
        press(5'b00001, DB, "clamp");
        chk("clamp_zero", dut_digits(), 0);
        press(5'b11000, DB, "ok_plus_up");
        chk("ok_plus_up_val", dut_digits(), 0);

        // Randomized operation mix
        for (int n = 0; n < 90; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: mask = 5'b00001;
                1: mask = 5'b00010;
                2, 3: mask = 5'b00100;
                4, 5, 6: mask = 5'b10000;
                7: mask = 5'b01000;
                8: mask = 5'($urandom_range(1, 31));
                default: mask = 5'b0;
            endcase
            if (mask == 5'b0) begin
                cur_H1 = 2'($urandom_range(0, 3));
                cur_H0 = 4'($urandom_range(0, 11));
                cur_M1 = 4'($urandom_range(0, 7));
                cur_M0 = 4'($urandom_range(0, 11));
            end else begin
                press(mask, DB + $urandom_range(0, 3), "rand");
            end
        end

        // Reset during COMMIT
        if (!m_edit) press(5'b00010, DB, "pre_commit_enter");
        press(5'b10000, DB, "pre_commit_up");
        @(negedge clk);
        btn_ok = 1'b1;
        model_press(5'b01000);
        repeat (3) @(negedge clk);
        btn_ok = 1'b0;
        @(negedge clk);
        chk("commit.strobe", int'(LD_time | LD_alarm), 1);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        chk("rst_commit.ld", int'({LD_time, LD_alarm}), 0);
        check_state("rst_commit");
        reset = 1'b1;
        press(5'b00010, DB, "post_reset_alarm");
        press(5'b00001, DB, "post_reset_cancel");

        repeat (4) @(negedge clk);
        chk("queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
